ysyx_22040895_ifu: RTL
======================

Name: ysyx_22040895_ifu

Overview:
- Instruction fetch unit. Upstream end of the decode interface: owns the PC, fetches 32-bit instructions from instruction memory over a valid/ready request/response channel, and presents the instruction with opcode/func3/func7 split out to the control unit.
- Consumes the control unit's jump/branch redirect (jump_branch + target) and squashes wrong-path fetches.
- One outstanding memory request, single-entry instruction hold register.

Parameters:
- PC_W, 64, PC and address width
- RESET_PC, 64'h8000_0000, first fetch address after reset
- INST_W, 32, instruction width (fixed 32; no compressed support)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req_valid_o  out  1  fetch request valid
- imem_req_addr_o  out  PC_W  fetch address (always word aligned)
- imem_req_ready_i  in  1  memory accepts request
- imem_rsp_valid_i  in  1  response data valid
- imem_rsp_data_i  in  INST_W  fetched instruction
- inst_valid_o  out  1  instruction held for decode
- inst_ready_i  in  1  decode/execute consumes held instruction
- inst_o  out  INST_W  held instruction
- pc_o  out  PC_W  PC of held instruction
- opcode_o  out  7  inst_o[6:0]
- func3_o  out  3  inst_o[14:12]
- func7_o  out  7  inst_o[31:25]
- jump_branch_i  in  1  redirect request (control unit jump_branch output)
- target_i  in  PC_W  redirect target PC
- fetch_err_o  out  1  misaligned-target error (see Optional Feature; else tied 0)

Behaviour:
- Reset: state=REQ, pc=RESET_PC, drop=0, inst_o=32'h0000_0013 (nop), inst_valid_o=0. While rst=1, imem_req_valid_o=0 and fetch_err_o=0.
- Field outputs are combinational slices of inst_o. pc_o is registered alongside inst_o.
- States:
  - REQ: imem_req_valid_o=1, addr=pc. On imem_req_ready_i, go to WAIT.
  - WAIT: no request. On imem_rsp_valid_i with drop=0: capture data into inst_o, pc into pc_o, go to HOLD. With drop=1: discard data, clear drop, go to REQ.
  - HOLD: inst_valid_o=1. On inst_ready_i: pc<=pc+4 (wraps modulo 2^PC_W), go to REQ.
- Memory responses never arrive in the same cycle as the accept. Responses in REQ or HOLD are ignored.
- Redirect (jump_branch_i=1) has priority over every other event in the same cycle. pc<=target_i & ~3 in all cases. Per state:
  - REQ without ready: stay in REQ; next request uses the new pc.
  - REQ with ready: the old-address request is issued; go to WAIT with drop=1.
  - WAIT without response: drop<=1.
  - WAIT with response: discard data, go to REQ.
  - HOLD (inst_ready_i ignored): go to REQ; inst_valid_o=0 next cycle.
- Redirect while drop already 1: drop stays 1; pc is updated again.
- Throughput: with a memory that is always ready and responds one cycle after accept, and decode always ready, one instruction every 3 cycles (REQ, WAIT, HOLD). First request is in the first cycle after rst deasserts.
- rst asserted mid-transaction: return to reset state immediately. Any later response to an in-flight request is ignored because the block is in REQ.
- Unknown opcodes are passed through unchanged; decoding is the control unit's job.

Optional Feature:
- Macro: YSYX_22040895_IFU_MISALIGN_CHK_EN
- Defined: a redirect with target_i[1:0]!=0 sets sticky fetch_err_o=1 and enters a terminal ERR state.
  - ERR: no requests, inst_valid_o=0, redirects ignored.
  - Only rst clears ERR.
  - pc<=target_i unmasked, for debug visibility.
- Not defined: fetch_err_o tied 0, no ERR state, target low two bits masked as above.

Test Plan:
- Reset release, memory always ready with 1-cycle latency, rsp=32'h0010_0093, decode always ready -> first request addr 0x8000_0000; inst_valid_o in cycle 3; opcode_o=7'h13, func3_o=0; second request addr 0x8000_0004.
- Hold stall: inst_ready_i=0 for 5 cycles -> inst_valid_o stays 1, inst_o/pc_o stable, no new request; consume -> next addr pc+4.
- Redirect in WAIT, target 0x8000_0100, response 2 cycles later -> response discarded, inst_valid_o never asserted for it, next request addr 0x8000_0100.
- Redirect with inst_ready_i in HOLD, target 0x8000_0040 -> next request 0x8000_0040, not pc+4.
- rst pulsed while in WAIT, stale response arrives after -> inst_valid_o=0, next request 0x8000_0000.
- With YSYX_22040895_IFU_MISALIGN_CHK_EN, target 0x8000_0102 -> fetch_err_o=1 next cycle, no further requests until rst. Without the macro -> next request 0x8000_0100.

Source files
------------

// File: rtl/ysyx_22040895_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22040895_ifu -- instruction fetch unit
//
// Owns the PC and fetches one 32-bit instruction at a time from instruction
// memory over a valid/ready request channel with a separate response strobe.
// Only one request is ever outstanding. The fetched word is kept in a
// single-entry hold register for the decode/control unit. The control unit can
// redirect the PC with jump_branch_i/target_i. Any fetch already in flight on
// the wrong path is discarded when its response returns.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   imem_req_valid_o    fetch request valid (forced low while rst=1)
//   imem_req_addr_o     fetch address (the current PC)
//   imem_req_ready_i    memory accepts the request
//   imem_rsp_valid_i    response strobe, imem_rsp_data_i carries the word
//   inst_valid_o        hold register holds an instruction for decode
//   inst_ready_i        decode consumes the held instruction
//   inst_o, pc_o        held instruction and the PC it was fetched from
//   opcode_o/func3_o/func7_o  field slices of inst_o
//   jump_branch_i       redirect request, target_i is the new PC
//   fetch_err_o         sticky misaligned-redirect error
//
// Optional feature: define YSYX_22040895_IFU_MISALIGN_CHK_EN to trap
// redirects whose target is not word aligned. Such a redirect puts the unit
// in a terminal ERR state that only rst clears. Without the macro, the
// target's low two bits are masked and fetch_err_o is tied to 0.
// ----------------------------------------------------------------------------
module ysyx_22040895_ifu #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000,
    parameter int              INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid_o,
    output logic [PC_W-1:0]   imem_req_addr_o,
    input  logic              imem_req_ready_i,
    input  logic              imem_rsp_valid_i,
    input  logic [INST_W-1:0] imem_rsp_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        func3_o,
    output logic [6:0]        func7_o,
    input  logic              jump_branch_i,
    input  logic [PC_W-1:0]   target_i,
    output logic              fetch_err_o
);

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [PC_W-1:0]   LOW2     = PC_W'(3);
    localparam logic [PC_W-1:0]   PC_STEP  = PC_W'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_inst_pc;
    logic [INST_W-1:0]   r_inst;
    logic                r_drop;     // the outstanding response belongs to a squashed path

    logic [PC_W-1:0]     w_target;

    assign w_target = target_i & ~LOW2;

`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
    logic w_misalign;
    assign w_misalign = jump_branch_i && (target_i[1:0] != 2'b00) && (r_state != S_ERR);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_inst_pc <= RESET_PC;
            r_inst    <= NOP_INST;
            r_drop    <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_req_ready_i) begin
                        r_state <= S_WAIT;
                    end
                    // A redirect in the accept cycle still lets the old-address
                    // request go out; its response must then be thrown away.
                    if (jump_branch_i) begin
                        r_pc <= w_target;
                        if (imem_req_ready_i) begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (r_drop || jump_branch_i) begin
                            // Wrong-path word: discard and refetch from the new PC.
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst    <= imem_rsp_data_i;
                            r_inst_pc <= r_pc;
                            r_state   <= S_HOLD;
                        end
                    end else if (jump_branch_i) begin
                        r_drop <= 1'b1;
                    end
                    if (jump_branch_i) begin
                        r_pc <= w_target;
                    end
                end
                S_HOLD: begin
                    // A redirect beats a consume: the held word is on the wrong path.
                    if (jump_branch_i) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (inst_ready_i) begin
                        r_pc    <= r_pc + PC_STEP;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    // Terminal error state: held until rst.
                end
            endcase
`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
            // Overrides whatever the state-specific branch decided above.
            if (w_misalign) begin
                r_state <= S_ERR;
                r_pc    <= target_i;   // keep the faulting target visible, unmasked
                r_drop  <= 1'b0;
            end
`endif
        end
    end

    assign imem_req_valid_o = (r_state == S_REQ) && !rst;
    assign imem_req_addr_o  = r_pc;
    assign inst_valid_o     = (r_state == S_HOLD);
    assign inst_o           = r_inst;
    assign pc_o             = r_inst_pc;
    assign opcode_o         = r_inst[6:0];
    assign func3_o          = r_inst[14:12];
    assign func7_o          = r_inst[31:25];

`ifdef YSYX_22040895_IFU_MISALIGN_CHK_EN
    assign fetch_err_o = (r_state == S_ERR) && !rst;
`else
    assign fetch_err_o = 1'b0;
`endif

endmodule
